// File: rtl/baud_autobaud_ctrl.sv
// UART baud divisor owner: oversampling tick generator with host-written or
// auto-baud-measured divisor, always switched on a tick boundary.
module baud_autobaud_ctrl #(
  parameter int N           = 16,
  parameter int OS_LOG2     = 4,
  parameter int DEFAULT_DIV = 27
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_rx,
  input  logic         i_autobaud,
  input  logic         i_wr_en,
  input  logic [N-1:0] i_wr_div,
  output logic         o_tick,
  output logic [N-1:0] o_div,
  output logic         o_busy,
  output logic         o_locked,
  output logic         o_err
);

  localparam int TW = N + OS_LOG2;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_HIGH  = 3'd1,
    S_WAIT_START = 3'd2,
    S_MEASURE    = 3'd3,
    S_CALC       = 3'd4,
    S_ERR        = 3'd5
  } state_t;

  logic [N-1:0]  cnt_r;
  logic [N-1:0]  div_r;
  logic [N-1:0]  pend_div_r;
  logic          pend_vld_r;
  logic          rx_meta_r;
  logic          rxs_r;
  logic          rxs_d_r;
  state_t        state_r;
  logic [TW-1:0] t_r;
  logic          busy_r;
  logic          locked_r;
  logic          err_r;

  logic          wrap_s;
  logic          wr_ok_s;
  logic          wr_rej_s;
  logic          fall_s;
  logic          rise_s;
  logic [TW:0]   t_round_s;
  logic [TW:0]   div_wide_s;
  logic          calc_ok_s;
  logic          stage_calc_s;

  assign wrap_s   = (cnt_r == (div_r - N'(1)));
  assign wr_ok_s  = i_wr_en && !busy_r && (i_wr_div >= N'(2));
  assign wr_rej_s = i_wr_en && !wr_ok_s;
  assign fall_s   = !rxs_r && rxs_d_r;
  assign rise_s   = rxs_r && !rxs_d_r;

  // Round-to-nearest at TW+1 bits; a quotient that does not fit N bits is
  // treated like a too-small one (measurement unusable).
  assign t_round_s    = {1'b0, t_r} + ((TW+1)'(1) << (OS_LOG2 - 1));
  assign div_wide_s   = t_round_s >> OS_LOG2;
  assign calc_ok_s    = (div_wide_s >= (TW+1)'(2)) &&
                        (div_wide_s[TW:N] == '0);
  assign stage_calc_s = (state_r == S_CALC) && calc_ok_s;

  assign o_tick   = wrap_s;
  assign o_div    = div_r;
  assign o_busy   = busy_r;
  assign o_locked = locked_r;
  assign o_err    = err_r;

  // Two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
      rxs_d_r   <= 1'b1;
    end else begin
      rx_meta_r <= i_rx;
      rxs_r     <= rx_meta_r;
      rxs_d_r   <= rxs_r;
    end
  end

  // Tick counter and divisor register; pending value loads only on the wrap
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_r      <= '0;
      div_r      <= N'(DEFAULT_DIV);
      pend_div_r <= '0;
      pend_vld_r <= 1'b0;
    end else begin
      if (wrap_s) begin
        cnt_r <= '0;
        if (pend_vld_r) begin
          div_r <= pend_div_r;
        end
      end else begin
        cnt_r <= cnt_r + N'(1);
      end
      // A stage coinciding with the wrap survives until the next wrap
      if (stage_calc_s) begin
        pend_div_r <= div_wide_s[N-1:0];
        pend_vld_r <= 1'b1;
      end else if (wr_ok_s) begin
        pend_div_r <= i_wr_div;
        pend_vld_r <= 1'b1;
      end else if (wrap_s) begin
        pend_vld_r <= 1'b0;
      end
    end
  end

  // Auto-baud FSM with registered status flags
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r  <= S_IDLE;
      t_r      <= '0;
      busy_r   <= 1'b0;
      locked_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      err_r <= wr_rej_s;
      if (wr_ok_s) begin
        locked_r <= 1'b0;
      end
      case (state_r)
        S_IDLE: begin
          if (i_autobaud) begin
            state_r  <= S_WAIT_HIGH;
            busy_r   <= 1'b1;
            locked_r <= 1'b0;
          end
        end
        S_WAIT_HIGH: begin
          if (rxs_r) begin
            state_r <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (fall_s) begin
            state_r <= S_MEASURE;
            t_r     <= TW'(1);
          end
        end
        S_MEASURE: begin
          if (rise_s) begin
            state_r <= S_CALC;
          end else if (t_r == {TW{1'b1}}) begin
            state_r <= S_ERR;
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
          end else if (!rxs_r) begin
            t_r <= t_r + TW'(1);
          end
        end
        S_CALC: begin
          if (calc_ok_s) begin
            state_r  <= S_IDLE;
            locked_r <= 1'b1;
            busy_r   <= 1'b0;
          end else begin
            state_r <= S_ERR;
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        S_ERR: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baud_autobaud_ctrl.sv
// Directed bench for baud_autobaud_ctrl; tick times checked via a scoreboard queue.
module tb_baud_autobaud_ctrl;

  localparam int N = 10;

  logic         clk;
  logic         rst;
  logic         rx;
  logic         ab;
  logic         wr_en;
  logic [N-1:0] wr_div;
  logic         tick;
  logic [N-1:0] div;
  logic         busy;
  logic         locked;
  logic         err;

  int checks = 0;
  int errors = 0;
  int cyc;
  bit track = 1'b0;
  int exp_q[$];

  baud_autobaud_ctrl #(.N(N), .OS_LOG2(4), .DEFAULT_DIV(27)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rx       (rx),
    .i_autobaud (ab),
    .i_wr_en    (wr_en),
    .i_wr_div   (wr_div),
    .o_tick     (tick),
    .o_div      (div),
    .o_busy     (busy),
    .o_locked   (locked),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (track && tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tick_at_cycle", cyc, -1);
      end else begin
        check("tick_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    int a;
    int guard;
    rst = 1'b1; rx = 1'b1; ab = 1'b0; wr_en = 1'b0; wr_div = '0;
    repeat (3) @(negedge clk);
    check("rst_div", int'(div), 27);
    check("rst_tick", int'(tick), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(26); exp_q.push_back(53); exp_q.push_back(80);
    exp_q.push_back(107); exp_q.push_back(161); exp_q.push_back(215);
    track = 1'b1;

    // host write of 54 while cnt==10
    wait_cyc(91);
    wr_en = 1'b1; wr_div = N'(54);
    @(negedge clk);
    wr_en = 1'b0;
    check("wr_no_err", int'(err), 0);
    wait_cyc(107); check("div_before_wrap", int'(div), 27);
    wait_cyc(108); check("div_after_wrap", int'(div), 54);

    for (int t = 269; t <= 755; t += 54) exp_q.push_back(t);
    for (int t = 782; t <= 1295; t += 27) exp_q.push_back(t);
    exp_q.push_back(1323); exp_q.push_back(1351);

    // rejected write: divisor too small
    wait_cyc(220);
    wr_en = 1'b1; wr_div = N'(1);
    @(negedge clk);
    wr_en = 1'b0;
    check("rej_small_err", int'(err), 1);
    @(negedge clk);
    check("rej_small_err_clear", int'(err), 0);
    check("rej_small_div", int'(div), 54);

    // auto-baud T=432 with a rejected write while busy
    wait_cyc(225);
    ab = 1'b1;
    @(negedge clk);
    ab = 1'b0;
    check("ab1_busy", int'(busy), 1);
    check("ab1_locked_clear", int'(locked), 0);
    wait_cyc(230);
    wr_en = 1'b1; wr_div = N'(40);
    @(negedge clk);
    wr_en = 1'b0;
    check("rej_busy_err", int'(err), 1);
    @(negedge clk);
    check("rej_busy_err_clear", int'(err), 0);
    wait_cyc(276); rx = 1'b0;
    wait_cyc(708); rx = 1'b1;
    wait_cyc(712);
    check("ab1_locked", int'(locked), 1);
    check("ab1_busy_clear", int'(busy), 0);
    check("ab1_div_not_yet", int'(div), 54);
    wait_cyc(756); check("ab1_div_applied", int'(div), 27);

    // auto-baud T=440
    wait_cyc(820);
    ab = 1'b1;
    @(negedge clk);
    ab = 1'b0;
    check("ab2_locked_clear", int'(locked), 0);
    wait_cyc(830); rx = 1'b0;
    wait_cyc(1270); rx = 1'b1;
    wait_cyc(1274);
    check("ab2_locked", int'(locked), 1);
    check("ab2_busy_clear", int'(busy), 0);
    wait_cyc(1295); check("ab2_div_not_yet", int'(div), 27);
    wait_cyc(1296); check("ab2_div_applied", int'(div), 28);
    wait_cyc(1355);
    check("tick_queue_drained", exp_q.size(), 0);
    track = 1'b0;

    // saturation: rx held low until the measurement counter tops out
    wait_cyc(1360);
    ab = 1'b1;
    @(negedge clk);
    ab = 1'b0;
    wait_cyc(1370); rx = 1'b0;
    while (err !== 1'b1 && cyc < 20000) @(negedge clk);
    check("sat_err_seen", int'(err), 1);
    check("sat_err_cycle", cyc, 17756);
    check("sat_busy", int'(busy), 0);
    check("sat_locked", int'(locked), 0);
    check("sat_div", int'(div), 28);
    @(negedge clk);
    check("sat_err_clear", int'(err), 0);
    rx = 1'b1;

    // glitch: T=20 rounds to 1
    a = cyc + 5;
    wait_cyc(a);
    ab = 1'b1;
    @(negedge clk);
    ab = 1'b0;
    wait_cyc(a + 10); rx = 1'b0;
    wait_cyc(a + 30); rx = 1'b1;
    wait_cyc(a + 33); check("glitch_no_err_early", int'(err), 0);
    wait_cyc(a + 34);
    check("glitch_err", int'(err), 1);
    check("glitch_busy", int'(busy), 0);
    wait_cyc(a + 35);
    check("glitch_err_clear", int'(err), 0);
    check("glitch_locked", int'(locked), 0);
    check("glitch_div", int'(div), 28);

    // write + auto-baud together at a wrap, then reset mid-measurement
    guard = 0;
    while (tick !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("tick_before_reset", int'(tick), 1);
    wr_en = 1'b1; wr_div = N'(100); ab = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; ab = 1'b0;
    check("both_busy", int'(busy), 1);
    check("both_no_err", int'(err), 0);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("measure_busy", int'(busy), 1);
    rst = 1'b1; rx = 1'b1;
    #1;
    check("mid_rst_div", int'(div), 27);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_locked", int'(locked), 0);
    check("mid_rst_err", int'(err), 0);
    check("mid_rst_tick", int'(tick), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(26); exp_q.push_back(53); exp_q.push_back(80);
    track = 1'b1;
    wait_cyc(60); check("post_rst_div", int'(div), 27);
    wait_cyc(100);
    check("post_rst_queue_drained", exp_q.size(), 0);
    check("post_rst_div_final", int'(div), 27);
    track = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
